// File: rtl/qtable_updater.sv
// qtable_updater: Bellman update client of the qtable BRAM; reads Q(s,a) and Q(s',0..3), writes Q(s,a).
// Define QUPD_SATURATE_EN to clamp q_new to the DATA_WIDTH signed range instead of wrapping.
module qtable_updater #(
    parameter int S_WIDTH     = 6,
    parameter int A_WIDTH     = 2,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ALPHA_SHIFT = 1,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [S_WIDTH-1:0]    i_state,
    input  logic [A_WIDTH-1:0]    i_action,
    input  logic [S_WIDTH-1:0]    i_next_state,
    input  logic [DATA_WIDTH-1:0] i_reward,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_done,
    output logic [A_WIDTH-1:0]    o_best_action
);
    localparam int W = DATA_WIDTH + 2;
    typedef enum logic [2:0] {IDLE, RD, WAIT, CALC, WR} state_t;
    state_t state, state_n;
    logic [2:0] cnt, cap_k;
    logic cap_v;
    logic [S_WIDTH-1:0] s_q, sp_q;
    logic [A_WIDTH-1:0] a_q, best;
    logic [DATA_WIDTH-1:0] r_q, qsa, mx, q_out;
    logic signed [W-1:0] r_e, q_e, mx_e, tgt, dlt, qn;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = i_valid ? RD : IDLE;
            RD:      state_n = (cnt == 3'd4) ? WAIT : RD;
            WAIT:    state_n = CALC;
            CALC:    state_n = WR;
            default: state_n = IDLE;
        endcase
    end

    assign o_ready   = state == IDLE;
    assign o_rd_en   = state == RD;
    assign o_wr_en   = state == WR;
    assign o_done    = o_wr_en;
    // cnt parks at 4 after the burst, so the last read address is held
    assign o_rd_addr = (cnt == 3'd0) ? {s_q, a_q} : {sp_q, A_WIDTH'(cnt - 3'd1)};

    assign r_e  = {{2{r_q[DATA_WIDTH-1]}}, r_q};
    assign q_e  = {{2{qsa[DATA_WIDTH-1]}}, qsa};
    assign mx_e = {{2{mx[DATA_WIDTH-1]}}, mx};
    assign tgt  = r_e + mx_e - (mx_e >>> GAMMA_SHIFT);
    assign dlt  = tgt - q_e;
    assign qn   = q_e + (dlt >>> ALPHA_SHIFT);

`ifdef QUPD_SATURATE_EN
    localparam logic signed [W-1:0] QMAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] QMIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};
    assign q_out = (qn > QMAX) ? QMAX[DATA_WIDTH-1:0] : (qn < QMIN) ? QMIN[DATA_WIDTH-1:0] : qn[DATA_WIDTH-1:0];
`else
    assign q_out = qn[DATA_WIDTH-1:0];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cap_v         <= 1'b0;
            cap_k         <= '0;
            s_q           <= '0;
            a_q           <= '0;
            sp_q          <= '0;
            r_q           <= '0;
            qsa           <= '0;
            mx            <= '0;
            best          <= '0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_best_action <= '0;
        end else begin
            state <= state_n;
            cap_v <= o_rd_en;
            cap_k <= cnt;
            if (o_ready && i_valid) begin
                s_q  <= i_state;
                a_q  <= i_action;
                sp_q <= i_next_state;
                r_q  <= i_reward;
                cnt  <= '0;
            end else if (o_rd_en && cnt != 3'd4) begin
                cnt <= cnt + 3'd1;
            end
            // strict greater-than keeps the lowest action index on ties
            if (cap_v) begin
                if (cap_k == 3'd0) begin
                    qsa <= i_rd_data;
                end else if (cap_k == 3'd1 || $signed(i_rd_data) > $signed(mx)) begin
                    mx   <= i_rd_data;
                    best <= A_WIDTH'(cap_k - 3'd1);
                end
            end
            if (state == CALC) begin
                o_wr_addr     <= {s_q, a_q};
                o_wr_data     <= q_out;
                o_best_action <= best;
            end
        end
    end
endmodule

// File: tb/tb_qtable_updater.sv
// tb_qtable_updater: directed vectors against a qtable memory model, plus reset-abort and back-to-back sequences.
module tb_qtable_updater;
    logic        i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0;
    logic [5:0]  i_state = '0, i_next_state = '0;
    logic [1:0]  i_action = '0;
    logic [31:0] i_reward = '0, i_rd_data = '0;
    logic        o_ready, o_rd_en, o_wr_en, o_done;
    logic [7:0]  o_rd_addr, o_wr_addr;
    logic [31:0] o_wr_data;
    logic [1:0]  o_best_action;

    qtable_updater dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_state(i_state), .i_action(i_action), .i_next_state(i_next_state), .i_reward(i_reward),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_done(o_done), .o_best_action(o_best_action)
    );

    always #5 i_clk = ~i_clk;

    // qtable model: 1-cycle registered read, synchronous write, plus bench clear/preload
    logic [31:0] mem [256];
    logic        clr = 1'b0, ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    always @(posedge i_clk) begin
        i_rd_data <= o_rd_en ? mem[o_rd_addr] : 32'hDEADBEEF;
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (ld_en) mem[ld_addr] <= ld_data;
            if (o_wr_en) mem[o_wr_addr] <= o_wr_data;
        end
    end

    typedef struct {
        logic [5:0]        s;
        logic [1:0]        a;
        logic [5:0]        sp;
        logic [31:0]       r;
        logic [31:0]       qsa;
        logic [3:0][31:0]  q;
        logic [31:0]       exp_data;
        logic [1:0]        exp_best;
    } vec_t;

    int checks = 0, errors = 0;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] ad, input logic [31:0] d);
        ld_addr = ad;
        ld_data = d;
        ld_en = 1'b1;
        @(negedge i_clk);
        ld_en = 1'b0;
    endtask

    task automatic clear_mem();
        clr = 1'b1;
        @(negedge i_clk);
        clr = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        logic [9:0]  rd_mask, wr_mask, done_mask, rdy_mask;
        logic [7:0]  rd_addr [$];
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [1:0]  bst;
        rd_mask = '0; wr_mask = '0; done_mask = '0; rdy_mask = '0;
        wa = '0; wd = '0; bst = '0;
        clear_mem();
        for (int k = 0; k < 4; k++) load({v.sp, 2'(k)}, v.q[k]);
        load({v.s, v.a}, v.qsa);
        i_state = v.s; i_action = v.a; i_next_state = v.sp; i_reward = v.r; i_valid = 1'b1;
        chk($sformatf("v%0d ready_before", n), 32'(o_ready), 32'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge i_clk);
            rdy_mask[k-1] = o_ready;
            if (o_rd_en) begin
                rd_mask[k-1] = 1'b1;
                rd_addr.push_back(o_rd_addr);
            end
            if (o_wr_en) begin
                wr_mask[k-1] = 1'b1;
                wa = o_wr_addr;
                wd = o_wr_data;
            end
            done_mask[k-1] = o_done;
            if (k == 9) bst = o_best_action;
        end
        chk($sformatf("v%0d ready_mask", n), 32'(rdy_mask), 32'b1100000000);
        chk($sformatf("v%0d rd_cycles", n), 32'(rd_mask), 32'b0000011111);
        chk($sformatf("v%0d rd_count", n), rd_addr.size(), 5);
        for (int k = 0; k < 5 && k < rd_addr.size(); k++)
            chk($sformatf("v%0d rd_addr%0d", n, k), 32'(rd_addr[k]),
                32'(k == 0 ? {v.s, v.a} : {v.sp, 2'(k - 1)}));
        chk($sformatf("v%0d wr_cycle", n), 32'(wr_mask), 32'b0010000000);
        chk($sformatf("v%0d done_cycle", n), 32'(done_mask), 32'b0010000000);
        chk($sformatf("v%0d wr_addr", n), 32'(wa), 32'({v.s, v.a}));
        chk($sformatf("v%0d wr_data", n), wd, v.exp_data);
        chk($sformatf("v%0d best", n), 32'(bst), 32'(v.exp_best));
        chk($sformatf("v%0d mem", n), mem[{v.s, v.a}], v.exp_data);
    endtask

    initial begin
        logic [31:0] sat_exp;
        logic [17:0] rdy_mask, wr_mask;
        logic [31:0] wd [$];
        int wr_cnt;
`ifdef QUPD_SATURATE_EN
        sat_exp = 32'h7FFFFFFF;
`else
        sat_exp = 32'hB7FE9000;
`endif
        vecs[0] = '{6'd5,  2'd2, 6'd9,  32'h00010000, 32'h0,
                    {32'h0, 32'h0, 32'h0, 32'h0}, 32'h00008000, 2'd0};
        vecs[1] = '{6'd10, 2'd1, 6'd20, 32'h0, 32'h0,
                    {32'h00040000, 32'h00020000, 32'h00040000, 32'h00010000}, 32'h0001C000, 2'd1};
        vecs[2] = '{6'd3,  2'd3, 6'd4,  32'h7FFF0000, 32'h7FFF0000,
                    {32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000}, sat_exp, 2'd0};
        vecs[3] = '{6'd7,  2'd0, 6'd8,  32'hFFFF0000, 32'h00020000,
                    {32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000}, 32'h00001000, 2'd0};
        vecs[4] = '{6'd12, 2'd3, 6'd12, 32'h00008000, 32'h00030000,
                    {32'h00030000, 32'h00050000, 32'hFFFF8000, 32'h00050000}, 32'h0003F000, 2'd0};
        vecs[5] = '{6'd33, 2'd1, 6'd62, 32'h0, 32'hFFFE0000,
                    {32'h00000001, 32'hFFFF8000, 32'hFFFF0000, 32'h80000000}, 32'hFFFF0000, 2'd3};

        clr = 1'b1;
        repeat (2) @(negedge i_clk);
        clr = 1'b0;
        chk("rst ready", 32'(o_ready), 32'd1);
        chk("rst rd_en", 32'(o_rd_en), 32'd0);
        chk("rst wr_en", 32'(o_wr_en), 32'd0);
        chk("rst done", 32'(o_done), 32'd0);
        chk("rst rd_addr", 32'(o_rd_addr), 32'd0);
        chk("rst wr_addr", 32'(o_wr_addr), 32'd0);
        chk("rst wr_data", o_wr_data, 32'd0);
        chk("rst best", 32'(o_best_action), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

        // reset asserted during cycle T+4 aborts the burst without a write
        clear_mem();
        i_state = 6'd17; i_action = 2'd1; i_next_state = 6'd18; i_reward = 32'h00010000; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("abort rd_en", 32'(o_rd_en), 32'd0);
        chk("abort ready", 32'(o_ready), 32'd1);
        chk("abort rd_addr", 32'(o_rd_addr), 32'd0);
        chk("abort best", 32'(o_best_action), 32'd0);
        chk("abort wr_data", o_wr_data, 32'd0);
        i_rst = 1'b0;
        wr_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            if (o_wr_en || o_done || o_rd_en) wr_cnt++;
        end
        chk("abort no_activity", 32'(wr_cnt), 32'd0);
        chk("abort ready_after", 32'(o_ready), 32'd1);

        // i_valid held: second accept at T+9, its write at T+17 sees the first write
        clear_mem();
        rdy_mask = '0; wr_mask = '0;
        i_state = 6'd1; i_action = 2'd0; i_next_state = 6'd2; i_reward = 32'h00010000; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_next_state = 6'd3; i_reward = 32'h0;
        for (int k = 1; k <= 18; k++) begin
            if (k > 1) @(negedge i_clk);
            if (k == 10) i_valid = 1'b0;
            rdy_mask[k-1] = o_ready;
            if (o_wr_en) begin
                wr_mask[k-1] = 1'b1;
                wd.push_back(o_wr_data);
            end
        end
        chk("b2b ready_mask", 32'(rdy_mask), 32'b100000000100000000);
        chk("b2b wr_mask", 32'(wr_mask), 32'b010000000010000000);
        chk("b2b wr_count", wd.size(), 2);
        if (wd.size() == 2) begin
            chk("b2b wr_data0", wd[0], 32'h00008000);
            chk("b2b wr_data1", wd[1], 32'h00004000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
